// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared states, opcode/func constants and datapath encodings for the multi-cycle MIPS controller
package mips_mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEM_ADDR = 4'd2;
    localparam state_t S_MEM_RD   = 4'd3;
    localparam state_t S_MEM_WB   = 4'd4;
    localparam state_t S_MEM_WR   = 4'd5;
    localparam state_t S_R_EXEC   = 4'd6;
    localparam state_t S_R_WB     = 4'd7;
    localparam state_t S_I_EXEC   = 4'd8;
    localparam state_t S_I_WB     = 4'd9;
    localparam state_t S_BRANCH   = 4'd10;
    localparam state_t S_JUMP     = 4'd11;
    localparam state_t S_JAL      = 4'd12;
    localparam state_t S_JR       = 4'd13;
    localparam state_t S_HALT     = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REGA   = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] ASB_B      = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    function automatic state_t decode_next(input logic [5:0] opcode, input logic [5:0] func);
        return opcode == OP_RTYPE ? (func == FN_JR ? S_JR : S_R_EXEC) :
               (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
               (opcode == OP_ADDI || opcode == OP_SLTI) ? S_I_EXEC :
               opcode == OP_BEQ ? S_BRANCH :
               opcode == OP_J ? S_JUMP :
               opcode == OP_JAL ? S_JAL : S_HALT;
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps an R-type func field to an ALU operation and flags unsupported funcs
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu_op,
    output logic       func_illegal
);

    // unsupported funcs fall back to AND and raise func_illegal so the FSM halts
    always_comb begin
        alu_op = func == FN_ADD ? ALU_ADD :
                 func == FN_SUB ? ALU_SUB :
                 func == FN_OR  ? ALU_OR  :
                 func == FN_SLT ? ALU_SLT : ALU_AND;
        func_illegal = !(func == FN_ADD || func == FN_SUB || func == FN_AND ||
                         func == FN_OR || func == FN_SLT);
    end

endmodule

// File: rtl/mips_multi_cycle_controller.sv
// mips_multi_cycle_controller: multi-cycle MIPS control FSM; define MIPS_MC_PERF_CNT_EN to build the cycle/instruction counters
module mips_multi_cycle_controller
    import mips_mc_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_load,
    output logic [1:0]       pc_src,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             instr_done,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t     state, state_nxt;
    logic [2:0] r_alu_op;
    logic       func_illegal;
    logic       timeout;

    mips_alu_decoder u_alu_dec (
        .func         (func),
        .alu_op       (r_alu_op),
        .func_illegal (func_illegal)
    );

    // FSM state; reset parks it in FETCH and abandons any access in flight
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_nxt;
    end

    generate
        if (MEM_TIMEOUT != 0) begin : g_timeout
            logic        waiting;
            logic [31:0] wait_cnt;
            assign waiting = (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR) && !mem_ready;
            // length of the current stall; cleared as soon as the access completes or the FSM moves on
            always_ff @(posedge clock or negedge rst) begin
                if (!rst) wait_cnt <= '0;
                else      wait_cnt <= waiting ? wait_cnt + 32'd1 : '0;
            end
            assign timeout = waiting && wait_cnt >= 32'(MEM_TIMEOUT);
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    // next state plus all control outputs; outputs are held at 0 while rst is low
    always_comb begin
        state_nxt  = state;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_load    = 1'b0;
        pc_src     = PC_ALU;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALUOUT;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ASB_B;
        alu_op     = ALU_AND;
        instr_done = 1'b0;
        halted     = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ASB_FOUR;
                    alu_op    = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_load   = mem_ready;
                    state_nxt = mem_ready ? S_DECODE : timeout ? S_HALT : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = ASB_IMM_SH;
                    alu_op    = ALU_ADD;
                    state_nxt = decode_next(opcode, func);
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ASB_IMM;
                    alu_op    = ALU_ADD;
                    state_nxt = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    iord      = 1'b1;
                    mem_read  = 1'b1;
                    state_nxt = mem_ready ? S_MEM_WB : timeout ? S_HALT : S_MEM_RD;
                end
                S_MEM_WB: begin
                    mem_to_reg = M2R_MDR;
                    reg_write  = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_MEM_WR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    state_nxt = mem_ready ? S_FETCH : timeout ? S_HALT : S_MEM_WR;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = r_alu_op;
                    state_nxt = func_illegal ? S_HALT : S_R_WB;
                end
                S_R_WB: begin
                    reg_dst   = RD_RD;
                    reg_write = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ASB_IMM;
                    alu_op    = opcode == OP_SLTI ? ALU_SLT : ALU_ADD;
                    state_nxt = S_I_WB;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PC_ALUOUT;
                    pc_load   = zero;
                    state_nxt = S_FETCH;
                end
                S_JUMP: begin
                    pc_src    = PC_JUMP;
                    pc_load   = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_JAL: begin
                    pc_src     = PC_JUMP;
                    pc_load    = 1'b1;
                    reg_dst    = RD_RA;
                    mem_to_reg = M2R_PC;
                    reg_write  = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_JR: begin
                    pc_src    = PC_REGA;
                    pc_load   = 1'b1;
                    state_nxt = S_FETCH;
                end
                default: begin
                    halted    = 1'b1;
                    state_nxt = S_HALT;
                end
            endcase
            instr_done = state != S_FETCH && state_nxt == S_FETCH;
        end
    end

`ifdef MIPS_MC_PERF_CNT_EN
    // active-cycle and retired-instruction counters, both frozen while halted
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instr_done)      instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multi_cycle_controller.sv
// tb_mips_multi_cycle_controller: directed per-cycle vectors checked by a queue-based scoreboard
module tb_mips_multi_cycle_controller;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  func = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        iord, mem_read, mem_write, ir_write, pc_load, reg_write, alu_src_a, instr_done, halted;
    logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [2:0]  alu_op;
    logic [31:0] cycle_cnt, instr_cnt;

    logic [19:0] exp_q[$];
    string       tag_q[$];
    logic [19:0] act, ex;
    string       tg;
    int          checks = 0;
    int          errors = 0;
    logic        prev_halt = 1'b0;
    logic [31:0] prev_icnt = '0;

    mips_multi_cycle_controller dut (
        .clock(clock), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_load(pc_load),
        .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
        .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clock = ~clock;

    assign act = {iord, mem_read, mem_write, ir_write, pc_load, pc_src, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, instr_done, halted};

    function automatic logic [19:0] e(input logic io, mr, mw, irw, pcl, input logic [1:0] pcs, rd, m2r,
                                      input logic rw, asa, input logic [1:0] asb, input logic [2:0] aop,
                                      input logic done, hlt);
        return {io, mr, mw, irw, pcl, pcs, rd, m2r, rw, asa, asb, aop, done, hlt};
    endfunction

    function automatic logic [19:0] x_fetch(input logic r);
        return e(0, 1, 0, r, r, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 3'b010, 0, 0);
    endfunction
    function automatic logic [19:0] x_dec();
        return e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 3'b010, 0, 0);
    endfunction
    function automatic logic [19:0] x_maddr();
        return e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2'b10, 3'b010, 0, 0);
    endfunction
    function automatic logic [19:0] x_mrd();
        return e(1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [19:0] x_mwb();
        return e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0, 2'b00, 3'b000, 1, 0);
    endfunction
    function automatic logic [19:0] x_mwr(input logic r);
        return e(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, r, 0);
    endfunction
    function automatic logic [19:0] x_rex(input logic [2:0] op);
        return e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, op, 0, 0);
    endfunction
    function automatic logic [19:0] x_rwb();
        return e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 2'b00, 3'b000, 1, 0);
    endfunction
    function automatic logic [19:0] x_iex(input logic [2:0] op);
        return e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2'b10, op, 0, 0);
    endfunction
    function automatic logic [19:0] x_iwb();
        return e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 3'b000, 1, 0);
    endfunction
    function automatic logic [19:0] x_br(input logic z);
        return e(0, 0, 0, 0, z, 2'b01, 2'b00, 2'b00, 0, 1, 2'b00, 3'b110, 1, 0);
    endfunction
    function automatic logic [19:0] x_j();
        return e(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 1, 0);
    endfunction
    function automatic logic [19:0] x_jal();
        return e(0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b10, 1, 0, 2'b00, 3'b000, 1, 0);
    endfunction
    function automatic logic [19:0] x_jr();
        return e(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 1, 0);
    endfunction
    function automatic logic [19:0] x_halt();
        return e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 1);
    endfunction

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy,
                        input logic [19:0] exp_v, input string tag);
        opcode = op;
        func = fn;
        zero = z;
        mem_ready = rdy;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            tg = tag_q.pop_front();
            checks++;
            if (act !== ex) begin
                errors++;
                $display("FAIL %s: got %b expected %b", tg, act, ex);
            end
`ifndef MIPS_MC_PERF_CNT_EN
            checks++;
            if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
                errors++;
                $display("FAIL %s counters: got %0d/%0d expected 0/0", tg, cycle_cnt, instr_cnt);
            end
`else
            if (ex[0] && prev_halt) begin
                checks++;
                if (instr_cnt !== prev_icnt) begin
                    errors++;
                    $display("FAIL %s instr_cnt frozen: got %0d expected %0d", tg, instr_cnt, prev_icnt);
                end
            end
            prev_halt = ex[0];
            prev_icnt = instr_cnt;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock);
        #1;
        step(6'b000000, 6'b000000, 0, 1, 20'd0, "reset");
        rst = 1'b1;
        step(6'b100011, 6'b000000, 0, 1, x_fetch(1), "lw fetch");
        step(6'b100011, 6'b000000, 0, 1, x_dec(), "lw decode");
        step(6'b100011, 6'b000000, 0, 1, x_maddr(), "lw addr");
        step(6'b100011, 6'b000000, 0, 1, x_mrd(), "lw read");
        step(6'b100011, 6'b000000, 0, 1, x_mwb(), "lw wb");
        for (int i = 0; i < 3; i++)
            step(6'b001000, 6'b000000, 0, 0, x_fetch(0), "fetch stall");
        step(6'b001000, 6'b000000, 0, 1, x_fetch(1), "fetch ready");
        step(6'b001000, 6'b000000, 0, 0, x_dec(), "addi decode");
        step(6'b001000, 6'b000000, 0, 1, x_iex(3'b010), "addi exec");
        step(6'b001000, 6'b000000, 0, 0, x_iwb(), "addi wb");
        step(6'b000100, 6'b000000, 1, 1, x_fetch(1), "beq1 fetch");
        step(6'b000100, 6'b000000, 1, 1, x_dec(), "beq1 decode");
        step(6'b000100, 6'b000000, 1, 1, x_br(1), "beq taken");
        step(6'b000100, 6'b000000, 0, 1, x_fetch(1), "beq0 fetch");
        step(6'b000100, 6'b000000, 0, 1, x_dec(), "beq0 decode");
        step(6'b000100, 6'b000000, 0, 1, x_br(0), "beq not taken");
        step(6'b000000, 6'b101010, 0, 1, x_fetch(1), "slt fetch");
        step(6'b000000, 6'b101010, 0, 1, x_dec(), "slt decode");
        step(6'b000000, 6'b101010, 0, 1, x_rex(3'b111), "slt exec");
        step(6'b000000, 6'b101010, 0, 1, x_rwb(), "slt wb");
        step(6'b000000, 6'b100010, 0, 1, x_fetch(1), "sub fetch");
        step(6'b000000, 6'b100010, 0, 1, x_dec(), "sub decode");
        step(6'b000000, 6'b100010, 1, 1, x_rex(3'b110), "sub exec");
        step(6'b000000, 6'b100010, 0, 1, x_rwb(), "sub wb");
        step(6'b000000, 6'b001000, 0, 1, x_fetch(1), "jr fetch");
        step(6'b000000, 6'b001000, 0, 1, x_dec(), "jr decode");
        step(6'b000000, 6'b001000, 0, 1, x_jr(), "jr");
        step(6'b001010, 6'b000000, 0, 1, x_fetch(1), "slti fetch");
        step(6'b001010, 6'b000000, 0, 1, x_dec(), "slti decode");
        step(6'b001010, 6'b000000, 0, 1, x_iex(3'b111), "slti exec");
        step(6'b001010, 6'b000000, 0, 1, x_iwb(), "slti wb");
        step(6'b000010, 6'b000000, 0, 1, x_fetch(1), "j fetch");
        step(6'b000010, 6'b000000, 0, 1, x_dec(), "j decode");
        step(6'b000010, 6'b000000, 0, 1, x_j(), "j");
        step(6'b000011, 6'b000000, 0, 1, x_fetch(1), "jal fetch");
        step(6'b000011, 6'b000000, 0, 1, x_dec(), "jal decode");
        step(6'b000011, 6'b000000, 0, 1, x_jal(), "jal");
        step(6'b101011, 6'b000000, 0, 1, x_fetch(1), "sw fetch");
        step(6'b101011, 6'b000000, 0, 1, x_dec(), "sw decode");
        step(6'b101011, 6'b000000, 0, 1, x_maddr(), "sw addr");
        step(6'b101011, 6'b000000, 0, 0, x_mwr(0), "sw stall");
        step(6'b101011, 6'b000000, 0, 1, x_mwr(1), "sw done");
        step(6'b101011, 6'b000000, 0, 1, x_fetch(1), "sw2 fetch");
        step(6'b101011, 6'b000000, 0, 1, x_dec(), "sw2 decode");
        step(6'b101011, 6'b000000, 0, 1, x_maddr(), "sw2 addr");
        step(6'b101011, 6'b000000, 0, 0, x_mwr(0), "sw2 stall a");
        step(6'b101011, 6'b000000, 0, 0, x_mwr(0), "sw2 stall b");
        rst = 1'b0;
        step(6'b101011, 6'b000000, 0, 1, 20'd0, "reset mid wait");
        rst = 1'b1;
        step(6'b111111, 6'b000000, 0, 0, x_fetch(0), "post reset fetch");
        step(6'b111111, 6'b000000, 0, 1, x_fetch(1), "bad fetch");
        step(6'b111111, 6'b000000, 0, 1, x_dec(), "bad decode");
        for (int i = 0; i < 4; i++)
            step(6'b100011, 6'b000000, 1, 1, x_halt(), "halt sticky");
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
